irq_rti_sequencer: RTL



---
 rtl/isa_ctrl_pkg.sv | 19 +
 rtl/flush_timer.sv | 19 +
 rtl/irq_rti_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/isa_ctrl_pkg.sv
// isa_ctrl_pkg: shared widths, vector address and sequencer state encoding for the decode-side control blocks.
package isa_ctrl_pkg;
    localparam int DEF_PC_WIDTH = 32;
    localparam int DEF_STK_WIDTH = 16;
    localparam int DEF_CCR_WIDTH = 3;
    localparam logic [31:0] DEF_VECTOR_ADDR = 32'h0000_0000;
    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_CCR,
        S_VECTOR,
        S_POP_CCR,
        S_POP_LO,
        S_POP_HI,
        S_RESUME,
        S_FLUSH
    } state_t;
endpackage

// File: rtl/flush_timer.sv
// flush_timer: loadable down-counter that reports done once the count reaches zero.
module flush_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (load) count <= load_val;
        else if (en && count != '0) count <= count - 1'b1;
    end
    assign done = count == '0;
endmodule

// File: rtl/irq_rti_sequencer.sv
// irq_rti_sequencer: interrupt entry / RTI exit sequencer over the 16-bit stack port.
// Define CCR_STACK_EN to also push/pop the condition codes; otherwise CCR bypasses the stack.
module irq_rti_sequencer
    import isa_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
    parameter int                  STK_WIDTH    = DEF_STK_WIDTH,
    parameter int                  CCR_WIDTH    = DEF_CCR_WIDTH,
    parameter logic [PC_WIDTH-1:0] VECTOR_ADDR  = DEF_VECTOR_ADDR,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 irq,
    input  logic                 rti_req,
    input  logic                 boundary_ok,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic [CCR_WIDTH-1:0] ccr_in,
    input  logic                 mem_ready,
    input  logic [STK_WIDTH-1:0] pop_data,
    output logic                 push_en,
    output logic                 pop_en,
    output logic [STK_WIDTH-1:0] push_data,
    output logic                 pc_load,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic                 ccr_load,
    output logic [CCR_WIDTH-1:0] ccr_out,
    output logic                 stall_fetch,
    output logic                 flush,
    output logic                 ack,
    output logic                 busy
);
`ifdef CCR_STACK_EN
    localparam state_t S_RTI_FIRST = S_POP_CCR;
    localparam state_t S_AFTER_LO = S_PUSH_CCR;
`else
    localparam state_t S_RTI_FIRST = S_POP_LO;
    localparam state_t S_AFTER_LO = S_VECTOR;
`endif
    state_t               state, state_nx;
    logic                 pending;
    logic [PC_WIDTH-1:0]  pc_hold;
    logic [CCR_WIDTH-1:0] ccr_hold;
    logic                 flush_done;
    logic                 go_rti, go_irq;

    assign go_rti = rti_req && boundary_ok;
    assign go_irq = (irq || pending) && boundary_ok;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = go_rti ? S_RTI_FIRST : go_irq ? S_PUSH_HI : S_IDLE;
            S_PUSH_HI:  state_nx = mem_ready ? S_PUSH_LO : state;
            S_PUSH_LO:  state_nx = mem_ready ? S_AFTER_LO : state;
            S_PUSH_CCR: state_nx = mem_ready ? S_VECTOR : state;
            S_VECTOR:   state_nx = S_FLUSH;
            S_POP_CCR:  state_nx = mem_ready ? S_POP_LO : state;
            S_POP_LO:   state_nx = mem_ready ? S_POP_HI : state;
            S_POP_HI:   state_nx = mem_ready ? S_RESUME : state;
            S_RESUME:   state_nx = S_FLUSH;
            S_FLUSH:    state_nx = flush_done ? S_IDLE : state;
            default:    state_nx = S_IDLE;
        endcase
    end

    // pending clears on the ack cycle; a request seen in that same cycle merges into the one being acked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            pc_hold  <= '0;
            ccr_hold <= '0;
        end else begin
            state   <= state_nx;
            pending <= (state == S_VECTOR) ? 1'b0 : (pending || irq);
            if (state == S_IDLE && !go_rti && go_irq) begin
                pc_hold  <= pc_in;
                ccr_hold <= ccr_in;
            end
            if (mem_ready && state == S_POP_CCR) ccr_hold <= pop_data[CCR_WIDTH-1:0];
            if (mem_ready && state == S_POP_LO) pc_hold[STK_WIDTH-1:0] <= pop_data;
            if (mem_ready && state == S_POP_HI) pc_hold[PC_WIDTH-1-:STK_WIDTH] <= pop_data;
        end
    end

    flush_timer #(.W(3)) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_nx == S_FLUSH && state != S_FLUSH),
        .load_val (3'(FLUSH_CYCLES - 1)),
        .en       (state == S_FLUSH),
        .done     (flush_done)
    );

    always_comb begin
        push_en     = state inside {S_PUSH_HI, S_PUSH_LO, S_PUSH_CCR};
        pop_en      = state inside {S_POP_CCR, S_POP_LO, S_POP_HI};
        push_data   = (state == S_PUSH_HI)  ? pc_hold[PC_WIDTH-1-:STK_WIDTH] :
                      (state == S_PUSH_LO)  ? pc_hold[STK_WIDTH-1:0] :
                      (state == S_PUSH_CCR) ? STK_WIDTH'(ccr_hold) : '0;
        pc_load     = state inside {S_VECTOR, S_RESUME};
        pc_out      = (state == S_VECTOR) ? VECTOR_ADDR : (state == S_RESUME) ? pc_hold : '0;
        ack         = state == S_VECTOR;
        flush       = state == S_FLUSH;
        busy        = state != S_IDLE;
        stall_fetch = busy;
`ifdef CCR_STACK_EN
        ccr_load    = state == S_RESUME;
        ccr_out     = (state == S_RESUME) ? ccr_hold : '0;
`else
        ccr_load    = 1'b0;
        ccr_out     = ccr_in;
`endif
    end
endmodule
